// File: rtl/rnn_fixed_pkg.sv
// Shared fixed-point definitions for the RNN gate datapath: default Q format,
// derived constants, saturation limits and the activation FSM state encoding.
package rnn_fixed_pkg;

  localparam int DEFAULT_QN = 6;
  localparam int DEFAULT_QM = 11;
  localparam int BITWIDTH   = DEFAULT_QN + DEFAULT_QM + 1;

  // 1.0 and 0.5 in the default Q format
  localparam logic signed [BITWIDTH-1:0] ONE  = BITWIDTH'(1 << DEFAULT_QM);
  localparam logic signed [BITWIDTH-1:0] HALF = BITWIDTH'(1 << (DEFAULT_QM - 1));

  // Saturation limits of the signed word
  localparam logic signed [BITWIDTH-1:0] SAT_MAX = {1'b0, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [BITWIDTH-1:0] SAT_MIN = {1'b1, {(BITWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/act_unit.sv
// Combinational per-row arithmetic: saturating dot+bias, then either a
// hard-sigmoid or a hard-tanh clamp, selected at elaboration by ACT_TYPE.
module act_unit
  import rnn_fixed_pkg::*;
#(
  parameter int QN       = DEFAULT_QN,
  parameter int QM       = DEFAULT_QM,
  parameter int ACT_TYPE = 0
) (
  input  logic signed [QN+QM:0] dot,
  input  logic signed [QN+QM:0] bias,
  output logic signed [QN+QM:0] result
);

  localparam int BW = QN + QM + 1;

  localparam logic signed [BW-1:0] SAT_HI    = {1'b0, {(BW-1){1'b1}}};
  localparam logic signed [BW-1:0] SAT_LO    = {1'b1, {(BW-1){1'b0}}};
  localparam logic signed [BW-1:0] ONE_N     = {{(BW-QM-1){1'b0}}, 1'b1, {QM{1'b0}}};
  localparam logic signed [BW-1:0] NEG_ONE_N = -ONE_N;
  // One extra bit of headroom for the sigmoid offset addition
  localparam logic signed [BW:0]   ONE_W     = {{(BW-QM){1'b0}}, 1'b1, {QM{1'b0}}};
  localparam logic signed [BW:0]   HALF_W    = {{(BW-QM+1){1'b0}}, 1'b1, {(QM-1){1'b0}}};

  logic signed [BW:0]   sum_wide;
  logic signed [BW-1:0] sum_sat;
  logic signed [BW-1:0] shifted;
  logic signed [BW:0]   sig_wide;
  logic signed [BW-1:0] sig_y;
  logic signed [BW-1:0] tanh_y;

  // Saturating add followed by both activation candidates and the final select
  always_comb begin
    sum_wide = {dot[BW-1], dot} + {bias[BW-1], bias};
    // Overflow shows up as disagreement between the two top bits
    if (sum_wide[BW] != sum_wide[BW-1]) begin
      sum_sat = sum_wide[BW] ? SAT_LO : SAT_HI;
    end else begin
      sum_sat = sum_wide[BW-1:0];
    end

    // Hard-sigmoid: floor(s/4) + 0.5, clamped to [0, 1]
    shifted  = sum_sat >>> 2;
    sig_wide = {shifted[BW-1], shifted} + HALF_W;
    if (sig_wide[BW]) begin
      sig_y = '0;
    end else if (sig_wide > ONE_W) begin
      sig_y = ONE_N;
    end else begin
      sig_y = sig_wide[BW-1:0];
    end

    // Hard-tanh: clamp to [-1, 1]
    if (sum_sat > ONE_N) begin
      tanh_y = ONE_N;
    end else if (sum_sat < NEG_ONE_N) begin
      tanh_y = NEG_ONE_N;
    end else begin
      tanh_y = sum_sat;
    end

    result = (ACT_TYPE == 1) ? tanh_y : sig_y;
  end

endmodule

// File: rtl/gate_activation.sv
// Vector activation stage: latches a dot-product vector plus bias on
// dataReady, then runs one row per cycle through a shared act_unit and
// pulses outValid once the whole output vector has been rewritten.
module gate_activation
  import rnn_fixed_pkg::*;
#(
  parameter int NROW     = 16,
  parameter int QN       = DEFAULT_QN,
  parameter int QM       = DEFAULT_QM,
  parameter int ACT_TYPE = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          dataReady,
  input  logic [NROW*(QN+QM+1)-1:0]     dotVec,
  input  logic [NROW*(QN+QM+1)-1:0]     biasVec,
  output logic [NROW*(QN+QM+1)-1:0]     outputVec,
  output logic                          outValid,
  output logic                          busy,
  output logic                          overrun
);

  localparam int BW = QN + QM + 1;
  localparam int RW = (NROW > 1) ? $clog2(NROW) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(NROW - 1);

  state_t               state_reg;
  state_t               state_next;
  logic [RW-1:0]        row_reg;
  logic [NROW*BW-1:0]   dot_reg;
  logic [NROW*BW-1:0]   bias_reg;
  logic                 overrun_reg;
  logic                 accept;

  logic [BW-1:0]        dot_rows  [NROW];
  logic [BW-1:0]        bias_rows [NROW];
  logic signed [BW-1:0] cur_dot;
  logic signed [BW-1:0] cur_bias;
  logic signed [BW-1:0] act_y;

  // Only IDLE accepts a new vector; anything arriving later is an overrun
  assign accept = (state_reg == IDLE) && dataReady;

  // Unpack the latched vectors into row arrays for the row mux
  generate
    for (genvar gi = 0; gi < NROW; gi++) begin : g_unpack
      assign dot_rows[gi]  = dot_reg[gi*BW +: BW];
      assign bias_rows[gi] = bias_reg[gi*BW +: BW];
    end
  endgenerate

  assign cur_dot  = dot_rows[row_reg];
  assign cur_bias = bias_rows[row_reg];

  act_unit #(
    .QN       (QN),
    .QM       (QM),
    .ACT_TYPE (ACT_TYPE)
  ) u_act (
    .dot    (cur_dot),
    .bias   (cur_bias),
    .result (act_y)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: IDLE -> PROC on accept, PROC -> DONE after the last row, DONE -> IDLE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (dataReady) state_next = PROC;
      PROC: if (row_reg == LAST_ROW) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Input latching and row sequencing
  always_ff @(posedge clock) begin
    if (reset) begin
      dot_reg  <= '0;
      bias_reg <= '0;
      row_reg  <= '0;
    end else if (accept) begin
      dot_reg  <= dotVec;
      bias_reg <= biasVec;
      row_reg  <= '0;
    end else if (state_reg == PROC && row_reg != LAST_ROW) begin
      row_reg <= row_reg + 1'b1;
    end
  end

  // Sticky overrun: set by any strobe that arrives while a vector is in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      overrun_reg <= 1'b0;
    end else if (dataReady && state_reg != IDLE) begin
      overrun_reg <= 1'b1;
    end
  end

  // Per-row output registers; each row only changes on its own PROC cycle
  generate
    for (genvar gi = 0; gi < NROW; gi++) begin : g_out
      logic [BW-1:0] out_row_reg;

      // Capture this row's activation when the row counter selects it
      always_ff @(posedge clock) begin
        if (reset) begin
          out_row_reg <= '0;
        end else if (state_reg == PROC && row_reg == RW'(gi)) begin
          out_row_reg <= act_y;
        end
      end

      assign outputVec[gi*BW +: BW] = out_row_reg;
    end
  endgenerate

  assign outValid = (state_reg == DONE);
  assign busy     = (state_reg != IDLE);
  assign overrun  = overrun_reg;

endmodule

// File: tb/tb_gate_activation.sv
// Scoreboard bench: two instances (hard-sigmoid and hard-tanh) share stimulus;
// expected vectors and arrival cycles are queued at issue time and checked by
// a monitor whenever outValid is seen.
module tb_gate_activation;

  localparam int NROW = 16;
  localparam int QN   = 6;
  localparam int QM   = 11;
  localparam int BW   = QN + QM + 1;
  localparam int VW   = NROW * BW;

  logic          clock = 1'b0;
  logic          reset;
  logic          dataReady;
  logic [VW-1:0] dotVec;
  logic [VW-1:0] biasVec;
  logic [VW-1:0] out_sig, out_tanh;
  logic          ov_sig, ov_tanh;
  logic          busy_sig, busy_tanh;
  logic          or_sig, or_tanh;

  gate_activation #(.NROW(NROW), .QN(QN), .QM(QM), .ACT_TYPE(0)) dut_sig (
    .clock(clock), .reset(reset), .dataReady(dataReady), .dotVec(dotVec),
    .biasVec(biasVec), .outputVec(out_sig), .outValid(ov_sig),
    .busy(busy_sig), .overrun(or_sig)
  );

  gate_activation #(.NROW(NROW), .QN(QN), .QM(QM), .ACT_TYPE(1)) dut_tanh (
    .clock(clock), .reset(reset), .dataReady(dataReady), .dotVec(dotVec),
    .biasVec(biasVec), .outputVec(out_tanh), .outValid(ov_tanh),
    .busy(busy_tanh), .overrun(or_tanh)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;
  int txn_sig    = 0;
  int txn_tanh   = 0;

  logic [VW-1:0] exp_sig_q[$];
  logic [VW-1:0] exp_tanh_q[$];
  int            cyc_sig_q[$];
  int            cyc_tanh_q[$];
  logic [VW-1:0] last_sig;

  int dot_a  [NROW];
  int bias_a [NROW];

  // Reference: real-valued rules on plain integers
  function automatic int ref_row(int d, int b, int act);
    int s, y, f;
    s = d + b;
    if (s > (1 << (BW-1)) - 1) s = (1 << (BW-1)) - 1;
    if (s < -(1 << (BW-1)))    s = -(1 << (BW-1));
    if (act == 0) begin
      f = (s >= 0) ? s / 4 : -((-s + 3) / 4);
      y = f + (1 << (QM-1));
      if (y < 0) y = 0;
      if (y > (1 << QM)) y = 1 << QM;
    end else begin
      y = s;
      if (y > (1 << QM))  y = 1 << QM;
      if (y < -(1 << QM)) y = -(1 << QM);
    end
    return y;
  endfunction

  function automatic int row_of(logic [VW-1:0] v, int r);
    logic signed [BW-1:0] x;
    x = v[r*BW +: BW];
    return int'(x);
  endfunction

  task automatic check_int(string name, int act, int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_vec(string name, logic [VW-1:0] act, logic [VW-1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      for (int r = 0; r < NROW; r++) begin
        if (act[r*BW +: BW] !== req[r*BW +: BW]) begin
          $display("FAIL %s: row %0d actual %0d required %0d (cycle %0d)",
                   name, r, row_of(act, r), row_of(req, r), cyc);
          break;
        end
      end
    end
  endtask

  // Monitor for the hard-sigmoid instance
  always @(negedge clock) begin
    if (ov_sig) begin
      if (exp_sig_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL sig_unexpected_valid: actual outValid=1 required none (cycle %0d)", cyc);
      end else begin
        logic [VW-1:0] e;
        int ec;
        e  = exp_sig_q.pop_front();
        ec = cyc_sig_q.pop_front();
        check_int("sig_latency", cyc, ec);
        check_vec("sig_vector", out_sig, e);
        txn_sig++;
        $display("txn sig #%0d cycle %0d row0=%0d row1=%0d", txn_sig, cyc,
                 row_of(out_sig, 0), row_of(out_sig, 1));
      end
    end
  end

  // Monitor for the hard-tanh instance
  always @(negedge clock) begin
    if (ov_tanh) begin
      if (exp_tanh_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL tanh_unexpected_valid: actual outValid=1 required none (cycle %0d)", cyc);
      end else begin
        logic [VW-1:0] e;
        int ec;
        e  = exp_tanh_q.pop_front();
        ec = cyc_tanh_q.pop_front();
        check_int("tanh_latency", cyc, ec);
        check_vec("tanh_vector", out_tanh, e);
        txn_tanh++;
        $display("txn tanh #%0d cycle %0d row0=%0d row1=%0d", txn_tanh, cyc,
                 row_of(out_tanh, 0), row_of(out_tanh, 1));
      end
    end
  end

  // Drive one strobe at the current negedge; optionally queue the expected result
  task automatic issue(input bit expect_out);
    logic [VW-1:0] dv, bv, es, et;
    int t, d, b;
    for (int r = 0; r < NROW; r++) begin
      d = dot_a[r];
      b = bias_a[r];
      dv[r*BW +: BW] = d[BW-1:0];
      bv[r*BW +: BW] = b[BW-1:0];
      t = ref_row(d, b, 0);
      es[r*BW +: BW] = t[BW-1:0];
      t = ref_row(d, b, 1);
      et[r*BW +: BW] = t[BW-1:0];
    end
    dotVec    = dv;
    biasVec   = bv;
    dataReady = 1'b1;
    if (expect_out) begin
      exp_sig_q.push_back(es);
      exp_tanh_q.push_back(et);
      cyc_sig_q.push_back(cyc + NROW + 1);
      cyc_tanh_q.push_back(cyc + NROW + 1);
      last_sig = es;
    end
    @(negedge clock);
    dataReady = 1'b0;
  endtask

  task automatic randomize_rows(input int span);
    for (int r = 0; r < NROW; r++) begin
      dot_a[r]  = int'($urandom_range(0, 2*span - 1)) - span;
      bias_a[r] = int'($urandom_range(0, 2*span - 1)) - span;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_sig || busy_tanh) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (busy_sig || busy_tanh) begin
      compared++;
      mismatched++;
      $display("FAIL wait_idle: actual busy=1 after %0d cycles required 0", n);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!ov_sig && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!ov_sig) begin
      compared++;
      mismatched++;
      $display("FAIL wait_valid: actual outValid=0 after %0d cycles required 1", n);
    end
  endtask

  task automatic check_reset_state(string tag);
    check_vec({tag, "_out_sig"},  out_sig,  '0);
    check_vec({tag, "_out_tanh"}, out_tanh, '0);
    check_int({tag, "_busy"},     int'(busy_sig) + int'(busy_tanh), 0);
    check_int({tag, "_valid"},    int'(ov_sig) + int'(ov_tanh), 0);
    check_int({tag, "_overrun"},  int'(or_sig) + int'(or_tanh), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    dataReady = 1'b0;
    dotVec    = '0;
    biasVec   = '0;
    last_sig  = '0;
    repeat (3) @(negedge clock);
    check_reset_state("reset");
    reset = 1'b0;
    @(negedge clock);

    // All-zero vector: sigmoid 0.5 everywhere, tanh 0
    for (int r = 0; r < NROW; r++) begin dot_a[r] = 0; bias_a[r] = 0; end
    issue(1'b1);
    wait_idle();

    // Sigmoid clamp at both ends
    randomize_rows(4000);
    dot_a[0] = 8192;  bias_a[0] = 0;
    dot_a[1] = -8192; bias_a[1] = 0;
    issue(1'b1);
    wait_idle();

    // Saturating add and in-range tanh
    randomize_rows(131072);
    dot_a[0] = 131071; bias_a[0] = 1;
    dot_a[1] = -1000;  bias_a[1] = -500;
    dot_a[2] = -131072; bias_a[2] = -5;
    issue(1'b1);
    wait_idle();

    // Back-to-back: second strobe on the first IDLE cycle after outValid
    randomize_rows(3000);
    issue(1'b1);
    wait_valid();
    @(negedge clock);
    randomize_rows(3000);
    issue(1'b1);
    wait_idle();
    check_int("b2b_overrun", int'(or_sig) + int'(or_tanh), 0);

    // Random vectors with mixed ranges, then hold check after completion
    for (int k = 0; k < 6; k++) begin
      randomize_rows((k % 2 == 0) ? 131072 : 5000);
      issue(1'b1);
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    repeat (3) @(negedge clock);
    check_vec("hold_after_valid", out_sig, last_sig);

    // Overrun: second strobe 5 cycles after the first is dropped
    randomize_rows(6000);
    issue(1'b1);
    repeat (4) @(negedge clock);
    randomize_rows(6000);
    issue(1'b0);
    wait_idle();
    check_int("overrun_sig",  int'(or_sig),  1);
    check_int("overrun_tanh", int'(or_tanh), 1);

    // Reset while row 7 is in flight: later rows still hold the previous vector
    randomize_rows(6000);
    issue(1'b0);
    repeat (7) @(negedge clock);
    check_int("mid_proc_hold_row15", row_of(out_sig, NROW-1), row_of(last_sig, NROW-1));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_reset_state("mid_reset");
    randomize_rows(131072);
    issue(1'b1);
    wait_idle();

    repeat (3) @(negedge clock);
    check_int("sig_queue_drained",  exp_sig_q.size(),  0);
    check_int("tanh_queue_drained", exp_tanh_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gate_activation.md
GATE_ACTIVATION -- requirements
Module: gate_activation

Interface
REQ-001: Parameter NROW, default 16, number of dot-product rows (lanes) per vector SHALL be set by this parameter.
REQ-002: Parameter QN, default 6, SHALL set the integer bits of the signed fixed-point format.
REQ-003: Parameter QM, default 11, SHALL set the fractional bits; BITWIDTH = QN+QM+1 (18).
REQ-004: Parameter ACT_TYPE, default 0, SHALL select the activation: 0 = hard-sigmoid, 1 = hard-tanh.
REQ-005: Ports SHALL be clock and reset: reset reset, synchronous, active-high; clock clock.
REQ-006: dataReady  input  1  SHALL be a single-cycle strobe from the upstream dot product marking dotVec valid.
REQ-007: dotVec  input  NROW*BITWIDTH  SHALL carry the dot-product results, row r at [r*BITWIDTH +: BITWIDTH].
REQ-008: biasVec  input  NROW*BITWIDTH  SHALL carry the per-row bias, sampled with dotVec.
REQ-009: outputVec  output  NROW*BITWIDTH  SHALL carry the activated vector, same packing.
REQ-010: outValid  output  1  SHALL be a one-cycle pulse marking outputVec complete.
REQ-011: busy  output  1  SHALL be high while a vector is in process.
REQ-012: overrun  output  1  SHALL be a sticky flag for a dataReady received while busy.

Function
REQ-013: The FSM SHALL have exactly three states: IDLE, PROC, DONE.
REQ-014: In IDLE, dataReady=1 SHALL latch dotVec and biasVec into internal registers, clear the row counter to 0, and go to PROC.
REQ-015: In PROC, one row per cycle SHALL be processed in order 0..NROW-1, writing only that row's slice of outputVec.
REQ-016: After row NROW-1, the FSM SHALL go to DONE; DONE SHALL assert outValid for exactly one cycle and then return to IDLE.
REQ-017: Latency SHALL be NROW+1 cycles from the dataReady edge to the outValid cycle; busy SHALL be high in PROC and DONE.
REQ-018: The sum s = dot + bias SHALL saturate to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1].
REQ-019: Hard-sigmoid SHALL be y = clamp((s >>> 2) + 2^(QM-1), 0, 2^QM), using an arithmetic shift (floor).
REQ-020: Hard-tanh SHALL be y = clamp(s, -2^QM, 2^QM).
REQ-021: A dataReady received in PROC or DONE SHALL be ignored for data and SHALL set overrun; overrun SHALL clear only on reset.
REQ-022: outputVec SHALL hold its value between outValid pulses; rows not yet rewritten SHALL keep their previous-vector values during PROC.
REQ-023: A dataReady in the same cycle that DONE returns to IDLE SHALL be ignored (no accept in DONE).

Reset
REQ-024: reset SHALL force IDLE and clear outputVec, outValid, busy, overrun, the row counter, and the latched vectors to 0 on the next rising clock edge.
REQ-025: reset asserted mid-PROC SHALL abort the vector with no outValid, and the block SHALL accept a new dataReady on the first cycle after reset deasserts.

Structure
REQ-026: BITWIDTH, the fixed-point constants (ONE = 2^QM, HALF = 2^(QM-1)), the saturation limits, and the state encoding SHALL reside in the shared package rnn_fixed_pkg.
REQ-027: The per-row arithmetic (saturating add plus activation) SHALL be a combinational sub-module act_unit, instantiated once and time-multiplexed across rows.

Verification
REQ-028: ACT_TYPE=0, all dot=0, bias=0 -> every row = 1024 (0.5), with outValid exactly 17 cycles after dataReady.
REQ-029: ACT_TYPE=0, row0 dot=8192, bias=0; row1 dot=-8192 -> row0 = 2048, row1 = 0 (clamped).
REQ-030: ACT_TYPE=1, dot=131071, bias=1 -> add saturates to 131071, output = 2048; dot=-1000, bias=-500 -> -1500.
REQ-031: dataReady pulsed again 5 cycles after the first -> second vector ignored, overrun=1, the first vector's outputs correct.
REQ-032: reset pulsed at row 7 of PROC -> no outValid, all outputs 0, and the next dataReady completes normally.
REQ-033: Back-to-back vectors, dataReady asserted on the first IDLE cycle after outValid -> both accepted, with no overrun.
